// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // Load in EX feeding either ID source; $0 is hard-wired and never hazards.
  function automatic logic load_use_hit(
    input logic             ex_load,
    input logic [REG_W-1:0] ex_wr,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt
  );
    return ex_load && (ex_wr != REG_ZERO) && ((ex_wr == id_rs) || (ex_wr == id_rt));
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module hazard_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (load-use, MEM branch, multi-cycle dmem).
// Define HAZARD_PERF_CNT_EN to add the LoadUseCnt/BranchFlushCnt/MemWaitCnt perf counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             EX_Mem2RegSEL,
  input  logic [REG_W-1:0] EX_WriteReg,
  input  logic             MEM_Mem2RegSEL,
  input  logic             MEM_MemWriteEN,
  input  logic             MEM_Branch,
  input  logic             MEM_ZeroFlag,
  input  logic             DMemReady,
  output logic             PC_EN,
  output logic             PCSrcSEL,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             EX_MEM_EN,
  output logic             MEM_WB_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             EX_MEM_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic             DMemReq,
  output logic             MemError
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] LoadUseCnt,
  output logic [CNT_W-1:0] BranchFlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_inc, wait_clr;
  logic             mem_op, br_taken, load_use, timeout;
  logic             hold, br_flush, lu_stall;

  hazard_sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .clr   (wait_clr),
    .en    (wait_inc),
    .count (wait_cnt)
  );

  always_comb begin
    mem_op   = MEM_Mem2RegSEL | MEM_MemWriteEN;
    br_taken = MEM_Branch & MEM_ZeroFlag;
    load_use = load_use_hit(EX_Mem2RegSEL, EX_WriteReg, ID_Rs, ID_Rt);
    timeout  = (state_q == MEM_WAIT) && !DMemReady && (wait_cnt == TIMEOUT_C);

    state_d     = state_q;
    mem_error_d = mem_error_q;
    wait_inc    = 1'b0;
    wait_clr    = 1'b0;
    hold        = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_op && !DMemReady) begin
          hold     = 1'b1;
          state_d  = MEM_WAIT;
          wait_inc = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (DMemReady || timeout) begin
          state_d  = RUN;
          wait_clr = 1'b1;
          if (!DMemReady) mem_error_d = 1'b1;
        end else begin
          hold     = 1'b1;
          wait_inc = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // A release cycle behaves like RUN, so a branch held behind its mem access resolves here.
    br_flush = ~hold & br_taken;
    lu_stall = ~hold & ~br_taken & load_use;

    PC_EN        = ~hold & ~lu_stall;
    IF_ID_EN     = ~hold & ~lu_stall;
    ID_EX_EN     = ~hold;
    EX_MEM_EN    = ~hold;
    MEM_WB_EN    = ~hold;
    PCSrcSEL     = br_flush;
    IF_ID_FLUSH  = br_flush;
    ID_EX_FLUSH  = br_flush | lu_stall;
    EX_MEM_FLUSH = br_flush;
    MEM_WB_FLUSH = hold;
    DMemReq      = (state_q == MEM_WAIT) | mem_op;

    if (!RESET_N) begin
      PC_EN        = 1'b0;
      IF_ID_EN     = 1'b0;
      ID_EX_EN     = 1'b0;
      EX_MEM_EN    = 1'b0;
      MEM_WB_EN    = 1'b0;
      PCSrcSEL     = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      EX_MEM_FLUSH = 1'b1;
      MEM_WB_FLUSH = 1'b1;
      DMemReq      = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= RUN;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign MemError = mem_error_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .clr   (1'b0),
    .en    (lu_stall),
    .count (LoadUseCnt)
  );

  hazard_sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .clr   (1'b0),
    .en    (br_flush),
    .count (BranchFlushCnt)
  );

  hazard_sat_counter #(.W(CNT_W)) u_mw_cnt (
    .clk   (CLOCK),
    .rst_n (RESET_N),
    .clr   (1'b0),
    .en    (hold),
    .count (MemWaitCnt)
  );
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable. Detects load-use hazards and taken branches resolved in MEM. Sequences multi-cycle data-memory accesses through a req/ready handshake, freezing the pipeline until the access completes or times out.

Parameters:
MEM_TIMEOUT, 255, max wait cycles for DMemReady before the access is abandoned (1..65535)
CNT_W, 16, width of the wait counter and the perf counters

Ports:
CLOCK  in  1  pipeline clock, rising edge
RESET_N  in  1  reset, asynchronous, active-low
ID_Rs  in  5  source reg 1 of instruction in ID
ID_Rt  in  5  source reg 2 of instruction in ID
EX_Mem2RegSEL  in  1  instruction in EX is a load
EX_WriteReg  in  5  destination reg of instruction in EX
MEM_Mem2RegSEL  in  1  instruction in MEM is a load
MEM_MemWriteEN  in  1  instruction in MEM is a store
MEM_Branch  in  1  instruction in MEM is a branch
MEM_ZeroFlag  in  1  ALU zero flag in MEM
DMemReady  in  1  data memory completes the access this cycle
PC_EN  out  1  PC write enable
PCSrcSEL  out  1  1 = load branch target into PC
IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1 each  register hold when 0
IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH  out  1 each  load bubble (all control bits 0)
DMemReq  out  1  data memory request
MemError  out  1  sticky timeout flag

Behaviour:
- Outputs are combinational from state and inputs (Mealy). Sample point is the CLOCK rising edge.
- States: RUN, MEM_WAIT.
- Reset (RESET_N=0, async): state=RUN, wait_cnt=0, MemError=0. While reset is held, all ENs=0, all FLUSHes=1, DMemReq=0, PCSrcSEL=0.
- Default in RUN: all ENs=1, FLUSHes=0, PCSrcSEL=0.
- mem_op = MEM_Mem2RegSEL | MEM_MemWriteEN. In RUN, DMemReq = mem_op.
- RUN, mem_op & ~DMemReady: all ENs=0 and PC_EN=0. MEM_WB_FLUSH=1, so WB does not commit twice. Next state MEM_WAIT, wait_cnt=1.
- RUN, mem_op & DMemReady: zero-wait access, normal advance.
- MEM_WAIT: DMemReq=1; pipeline frozen as above.
  - DMemReady=1: this cycle all ENs=1 and MEM_WB_FLUSH=0; next state RUN, wait_cnt=0.
  - Else, wait_cnt==MEM_TIMEOUT: set MemError; advance as if ready (load data undefined); next state RUN.
  - Else: wait_cnt++.
- Branch taken (MEM_Branch & MEM_ZeroFlag) in RUN: PCSrcSEL=1, IF_ID_FLUSH=ID_EX_FLUSH=EX_MEM_FLUSH=1, all ENs=1. Lasts one cycle.
- Load-use (EX_Mem2RegSEL, EX_WriteReg!=0, EX_WriteReg equal to ID_Rs or ID_Rt) in RUN: PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1. Other stages advance. Lasts one cycle, since the next cycle the load has moved to MEM.
- Priority: mem stall > branch flush > load-use.
  - Branch and load-use together: branch wins; the hazard disappears because it is flushed.
  - Branch in MEM never carries a mem_op. If both are asserted, treat as mem_op and complete the stall first; the branch resolves on the release cycle.
- Register $0 never causes a load-use stall.
- Reset asserted mid-wait: immediate return to RUN, DMemReq drops asynchronously.
- MemError is cleared only by reset.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs LoadUseCnt, BranchFlushCnt and MemWaitCnt (CNT_W each), reset to 0. Each increments by 1 per cycle of its condition and saturates at all-ones.
- Undefined: the ports and counters are absent. Control behaviour is identical.

Decomposition:
- Shared package pipe_pkg: state encoding (RUN=1'b0, MEM_WAIT=1'b1), register-number width 5, constant REG_ZERO=5'd0.
- Sub-module hazard_sat_counter (saturating, enable, async active-low reset). Used for the perf counters and reusable for wait_cnt.

Test Plan:
- RESET_N=0 at cycle 3, mid-MEM_WAIT -> DMemReq=0 immediately, all FLUSH=1. After release: state RUN, MemError=0.
- Load to $5 in EX, ID_Rt=5 -> exactly 1 cycle with PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1. Repeat with EX_WriteReg=0 -> no stall.
- MEM load, DMemReady rises after 3 cycles -> DMemReq high 4 cycles, ENs=0 for 3 cycles, release on cycle 4, MemError=0.
- MEM_Branch=1, MEM_ZeroFlag=1 with a concurrent load-use -> PCSrcSEL=1 and three FLUSHes for 1 cycle, PC_EN=1, no stall.
- MEM_TIMEOUT=4, DMemReady held 0 -> release after cycle 5, MemError=1 and sticky through subsequent accesses.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls + 1 branch + 3-cycle wait -> LoadUseCnt=2, BranchFlushCnt=1, MemWaitCnt=3.
